// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the ISA regression sequencer.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RESET = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [4:0]  REG_A0            = 5'd10;
  localparam logic [4:0]  REG_A7            = 5'd17;
  localparam logic [31:0] EXIT_CODE_DEF     = 32'h0000_005d;
  localparam logic [31:0] TIMEOUT_FAIL_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/riscv_test_reg_shadow.sv
// Tracks the last values written to a7 and a0 through the regfile writeback port.
module riscv_test_reg_shadow
  import riscv_test_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr,
  input  logic        en_a7,
  input  logic        en_a0,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] a7,
  output logic [31:0] a0
);

  // Shadow registers; the two enables are separate so a7 can freeze while a0 still updates
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a7 <= 32'd0;
      a0 <= 32'd0;
    end else if (clr) begin
      a7 <= 32'd0;
      a0 <= 32'd0;
    end else begin
      if (en_a7 && wb_valid && (wb_rd == REG_A7)) begin
        a7 <= wb_data;
      end
      if (en_a0 && wb_valid && (wb_rd == REG_A0)) begin
        a0 <= wb_data;
      end
    end
  end

endmodule

// File: rtl/riscv_test_sequencer.sv
// Runs a list of compliance images through the core: load, reset, run to the
// a7 exit convention, drain, then judge pass/fail from a0 under a watchdog.
module riscv_test_sequencer
  import riscv_test_pkg::*;
#(
  parameter int          NUM_TESTS    = 46,
  parameter int          IDX_W        = 6,
  parameter int          TIMEOUT_CYC  = 1500000,
  parameter int          DRAIN_CYC    = 5,
  parameter int          RST_CYC      = 2,
  parameter logic [31:0] EXIT_CODE    = EXIT_CODE_DEF,
  parameter int          STOP_ON_FAIL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             load_req_o,
  output logic [IDX_W-1:0] load_idx_o,
  input  logic             load_done_i,
  output logic             core_rst_o,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [31:0]      wb_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             result_valid_o,
  output logic             result_pass_o,
  output logic [IDX_W-1:0] result_idx_o,
  output logic [31:0]      fail_code_o,
  output logic [IDX_W:0]   pass_cnt_o,
  output logic [IDX_W:0]   fail_cnt_o,
  output logic             timeout_o
);

  localparam int CW = IDX_W + 1;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cnt;
  logic [31:0]      wd;
  logic [31:0]      a7;
  logic [31:0]      a0;
  logic             exit_hit;
  logic             wd_hit;
  logic             judge_pass;
  logic             last_test;
  logic             start_fire;
  logic             check_fire;
  logic             to_fire;

  riscv_test_reg_shadow u_shadow (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (state == ST_LOAD),
    .en_a7    (state == ST_RUN),
    .en_a0    ((state == ST_RUN) || (state == ST_DRAIN)),
    .wb_valid (wb_valid_i),
    .wb_rd    (wb_rd_i),
    .wb_data  (wb_data_i),
    .a7       (a7),
    .a0       (a0)
  );

  assign exit_hit   = (a7 == EXIT_CODE);
  assign wd_hit     = (wd == 32'(TIMEOUT_CYC - 1));
  assign judge_pass = (a0 == 32'd0);
  assign last_test  = (idx == IDX_W'(NUM_TESTS - 1));
  assign start_fire = ((state == ST_IDLE) || (state == ST_DONE)) && start_i;
  assign check_fire = (state == ST_CHECK);
  assign to_fire    = (state == ST_RUN) && !exit_hit && wd_hit;

  // Next-state logic; exit detect is tested before the watchdog so it wins a tie
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) state_nxt = ST_LOAD;
        else         state_nxt = state;
      end
      ST_LOAD: begin
        if (load_done_i) state_nxt = ST_RESET;
        else             state_nxt = ST_LOAD;
      end
      ST_RESET: begin
        if (cnt == 32'(RST_CYC - 1)) state_nxt = ST_RUN;
        else                         state_nxt = ST_RESET;
      end
      ST_RUN: begin
        if (exit_hit)    state_nxt = ST_DRAIN;
        else if (wd_hit) state_nxt = ST_DONE;
        else             state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (cnt == 32'(DRAIN_CYC - 1)) state_nxt = ST_CHECK;
        else                           state_nxt = ST_DRAIN;
      end
      ST_CHECK: begin
        if (!judge_pass && (STOP_ON_FAIL != 0)) state_nxt = ST_DONE;
        else if (last_test)                     state_nxt = ST_DONE;
        else                                    state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, phase counter and watchdog
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= 32'd0;
      wd    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
      wd    <= (state == ST_RUN) ? wd + 32'd1 : 32'd0;
    end
  end

  // Run bookkeeping; results register on the edge leaving CHECK or the timed-out RUN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx            <= '0;
      result_valid_o <= 1'b0;
      result_pass_o  <= 1'b0;
      result_idx_o   <= '0;
      fail_code_o    <= 32'd0;
      pass_cnt_o     <= '0;
      fail_cnt_o     <= '0;
      timeout_o      <= 1'b0;
    end else begin
      result_valid_o <= check_fire || to_fire;
      result_pass_o  <= check_fire && judge_pass;
      if (start_fire) begin
        idx         <= '0;
        fail_code_o <= 32'd0;
        pass_cnt_o  <= '0;
        fail_cnt_o  <= '0;
        timeout_o   <= 1'b0;
      end
      if (check_fire) begin
        result_idx_o <= idx;
        if (judge_pass) begin
          pass_cnt_o <= pass_cnt_o + CW'(1);
        end else begin
          fail_cnt_o  <= fail_cnt_o + CW'(1);
          fail_code_o <= a0;
        end
        if (state_nxt == ST_LOAD) idx <= idx + IDX_W'(1);
      end
      if (to_fire) begin
        result_idx_o <= idx;
        fail_cnt_o   <= fail_cnt_o + CW'(1);
        fail_code_o  <= TIMEOUT_FAIL_CODE;
        timeout_o    <= 1'b1;
      end
    end
  end

  assign load_req_o = (state == ST_LOAD);
  assign load_idx_o = idx;
  assign core_rst_o = !((state == ST_RUN) || (state == ST_DRAIN));
  assign busy_o     = (state == ST_LOAD) || (state == ST_RESET) || (state == ST_RUN) ||
                      (state == ST_DRAIN) || (state == ST_CHECK);
  assign done_o     = (state == ST_DONE);

endmodule

// File: doc/riscv_test_sequencer.md
Name: riscv_test_sequencer

Overview:
Synthesizable sequencer for the ISA regression flow: runs a list of NUM_TESTS compliance images through the core, one at a time.
- Per test: requests an image load, holds the core in reset, releases it, then watches the regfile writeback port for the exit convention (a7 = EXIT_CODE).
- After a drain window it judges pass/fail from a0, with a per-test watchdog.
- Replaces hierarchical register peeking and fixed delays. Sits beside top, driving core reset and the image loader.

Parameters:
NUM_TESTS, 46, number of images in the run list (1..2^IDX_W)
IDX_W, 6, width of test index
TIMEOUT_CYC, 1500000, max RUN cycles per test before timeout (32-bit compare)
DRAIN_CYC, 5, cycles between exit detect and a0 sampling (>=1)
RST_CYC, 2, cycles core_rst_o stays high after load_done_i (>=1)
EXIT_CODE, 32'h5d, a7 value signalling test end
STOP_ON_FAIL, 1, 1 = stop on first fail; 0 = continue the list

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  pulse; starts a run from DONE/IDLE; ignored otherwise
load_req_o  out  1  image load request
load_idx_o  out  IDX_W  image index to load; stable while load_req_o high
load_done_i  in  1  loader finished (single-cycle pulse or level)
core_rst_o  out  1  active-high reset to core
wb_valid_i  in  1  regfile write strobe
wb_rd_i  in  5  destination register
wb_data_i  in  32  write data
busy_o  out  1  run in progress
done_o  out  1  run finished
result_valid_o  out  1  one-cycle pulse per judged test
result_pass_o  out  1  qualified by result_valid_o
result_idx_o  out  IDX_W  index of judged test
fail_code_o  out  32  last failing a0 (testnum = [31:1]); 32'hFFFF_FFFF on timeout
pass_cnt_o  out  IDX_W+1  tests passed this run
fail_cnt_o  out  IDX_W+1  tests failed this run
timeout_o  out  1  sticky; watchdog expired this run

Behaviour:
- States: IDLE, LOAD, RESET, RUN, DRAIN, CHECK, DONE.
- Reset values: state IDLE; core_rst_o 1; every other output 0; shadows 0; idx 0.
- IDLE/DONE + start_i:
  - clear counters, fail_code_o, timeout_o; idx = 0; next state LOAD.
  - done_o falls the cycle after start_i.
- LOAD:
  - load_req_o = 1, load_idx_o = idx; a7/a0 shadows cleared on entry.
  - Exit when load_done_i is sampled 1. load_req_o drops the same cycle the state leaves LOAD.
- RESET: counts RST_CYC cycles, then RUN. Watchdog cleared on entry to RUN.
- core_rst_o: 1 in IDLE, LOAD, RESET, CHECK, DONE; 0 in RUN and DRAIN.
- Shadow tracking:
  - On wb_valid_i with wb_rd_i = 17, a7 shadow <= wb_data_i; with wb_rd_i = 10, a0 shadow <= wb_data_i.
  - Writes to other registers, including x0, are ignored.
  - Shadows update only in RUN and DRAIN.
- RUN:
  - Exit detect: registered a7 shadow == EXIT_CODE → DRAIN. Detect is one cycle after the writeback.
  - Watchdog: increments each RUN cycle; when it reaches TIMEOUT_CYC → timeout.
  - Exit detect and watchdog expiry in the same cycle: exit detect wins.
- Timeout:
  - result_valid_o pulses with pass = 0; fail_code_o = FFFF_FFFF; fail_cnt++; timeout_o = 1.
  - Always → DONE, regardless of STOP_ON_FAIL.
- DRAIN:
  - counts DRAIN_CYC cycles, then CHECK.
  - a0 writes during DRAIN are honoured; a7 changes are ignored.
- CHECK (1 cycle):
  - result_valid_o = 1, result_idx_o = idx, result_pass_o = (a0 shadow == 0).
  - Pass: pass_cnt++. Fail: fail_cnt++, fail_code_o = a0.
  - Next state:
    - fail and STOP_ON_FAIL → DONE;
    - else idx == NUM_TESTS-1 → DONE;
    - else idx++ → LOAD.
- DONE: done_o = 1, busy_o = 0. busy_o = 1 in LOAD through CHECK.
- Counters never wrap: width IDX_W+1 holds NUM_TESTS.
- rst_i mid-run: all state returns to reset values at once; an in-flight load request drops asynchronously.

Decomposition:
- Package riscv_test_pkg:
  - state enum;
  - REG_A0 = 10, REG_A7 = 17;
  - EXIT_CODE default;
  - TIMEOUT_FAIL_CODE = 32'hFFFF_FFFF.
- One sub-module, riscv_test_reg_shadow: a7/a0 writeback tracker with clear and enable.

Test Plan:
- NUM_TESTS=3, each image writes a7 = 5d then a0 = 0 → three result_valid_o pulses with pass = 1, idx 0,1,2; pass_cnt = 3; done_o = 1.
- Test 1 writes a0 = 0x0000_0007 → result_pass_o = 0, fail_code_o = 7; STOP_ON_FAIL=1: done_o after idx 1, load_idx_o never reaches 2, fail_cnt = 1.
- Same stimulus, STOP_ON_FAIL=0 → all 3 judged; pass_cnt = 2, fail_cnt = 1.
- TIMEOUT_CYC=100, image never writes a7 → result after exactly 100 RUN cycles; fail_code_o = FFFF_FFFF, timeout_o = 1, done_o = 1.
- load_done_i delayed 50 cycles → load_req_o held 50 cycles with stable load_idx_o; core_rst_o high until RST_CYC cycles after load_done_i.
- Assert rst_i during DRAIN → next cycle all outputs at reset values, core_rst_o = 1; start_i then restarts from idx 0 with counters 0.
